// File: rtl/uart_pkg.sv
// Shared UART definitions: default character geometry, line levels for the
// frame delimiters, and the transmit state encoding.
package uart_pkg;

    localparam int DEF_BYTE_SIZE = 8;
    localparam int DEF_FREQ_COEF = 16;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } tx_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// Serializes one UART character (start, LSB-first data, stop) with its own
// bit-period counter; chains characters with no idle gap when fed on time.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int BYTE_SIZE = DEF_BYTE_SIZE,
    parameter int FREQ_COEF = DEF_FREQ_COEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 i_valid,
    input  logic [BYTE_SIZE-1:0] i_byte,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_done,
    output logic [2:0]           o_state
);

    localparam int BAUD_W = $clog2(FREQ_COEF);
    localparam int BIT_W  = $clog2(BYTE_SIZE + 1);

    tx_state_t            state;
    logic [BAUD_W-1:0]    baud;
    logic [BIT_W-1:0]     bit_idx;
    logic [BYTE_SIZE-1:0] shreg;
    logic                 baud_end;

    // Handshake: a character is taken on any cycle with i_valid && o_ready.
    // o_ready is high when idle and on the last cycle of a stop bit, so a
    // character offered then starts on the very next cycle.
    assign baud_end = (baud == BAUD_W'(FREQ_COEF - 1));
    assign o_done   = (state == STOP) && baud_end;
    assign o_ready  = (state == IDLE) || o_done;
    assign o_state  = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            o_tx    <= STOP_BIT;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        shreg <= i_byte;
                        o_tx  <= START_BIT;
                        baud  <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud    <= '0;
                        o_tx    <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_idx == BIT_W'(BYTE_SIZE - 1)) begin
                            o_tx  <= STOP_BIT;
                            state <= STOP;
                        end else begin
                            o_tx    <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (i_valid) begin
                            shreg <= i_byte;
                            o_tx  <= START_BIT;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    o_tx  <= STOP_BIT;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_msg_tx.sv
// Message transmitter: sends opt, clamped len, then len payload bytes as
// back-to-back UART characters, followed by a one-cycle DONE.
module uart_msg_tx
    import uart_pkg::*;
#(
    parameter int BYTE_SIZE    = DEF_BYTE_SIZE,
    parameter int FREQ_COEF    = DEF_FREQ_COEF,
    parameter int DATA_BYTES   = 8,
    parameter int IN_DATA_SIZE = DATA_BYTES * BYTE_SIZE
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    i_valid,
    input  logic [BYTE_SIZE-1:0]    i_opt,
    input  logic [BYTE_SIZE-1:0]    i_len,
    input  logic [IN_DATA_SIZE-1:0] i_data,
    output logic                    o_ready,
    output logic                    o_tx,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int IDX_W = $clog2(DATA_BYTES + 3);
    localparam logic [BYTE_SIZE-1:0] MAX_LEN = BYTE_SIZE'(DATA_BYTES);

    tx_state_t             msg_st;
    tx_state_t             state;
    logic [IDX_W-1:0]      byte_idx;
    logic [IDX_W-1:0]      total;
    logic [BYTE_SIZE-1:0]  len_q;
    logic [BYTE_SIZE-1:0]  len_c;
    logic [IN_DATA_SIZE-1:0] data_q;
    logic [BYTE_SIZE-1:0]  byte_sel;
    logic [BYTE_SIZE-1:0]  byte_data;
    logic                  accept;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  byte_done;
    logic [2:0]            byte_state;

    assign o_ready = (msg_st == IDLE) && !RST;
    assign accept  = i_valid && o_ready;
    assign len_c   = (i_len > MAX_LEN) ? MAX_LEN : i_len;
    assign total   = IDX_W'(len_q) + IDX_W'(2);

    // The opt byte goes straight to the serializer in the accept cycle so its
    // start bit lands on the next cycle; later bytes come from the latches.
    always_comb begin
        byte_sel = len_q;
        for (int k = 0; k < DATA_BYTES; k++) begin
            if (byte_idx == IDX_W'(k + 2)) byte_sel = data_q[k*BYTE_SIZE +: BYTE_SIZE];
        end
    end

    assign byte_data  = accept ? i_opt : byte_sel;
    assign byte_valid = accept || ((msg_st == START) && (byte_idx < total));

    // Full message-level state: the serializer's phase while sending.
    always_comb begin
        state = (msg_st == START) ? tx_state_t'(byte_state) : msg_st;
    end

    assign o_busy = (state != IDLE);
    assign o_done = (state == DONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            msg_st   <= IDLE;
            byte_idx <= '0;
            len_q    <= '0;
            data_q   <= '0;
        end else begin
            case (msg_st)
                IDLE: begin
                    if (accept) begin
                        len_q    <= len_c;
                        data_q   <= i_data;
                        byte_idx <= IDX_W'(1);
                        msg_st   <= START;
                    end
                end
                START: begin
                    if (byte_valid && byte_ready) byte_idx <= byte_idx + 1'b1;
                    if (byte_done && !byte_valid) msg_st <= DONE;
                end
                DONE: begin
                    byte_idx <= '0;
                    msg_st   <= IDLE;
                end
                default: msg_st <= IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .BYTE_SIZE (BYTE_SIZE),
        .FREQ_COEF (FREQ_COEF)
    ) u_tx_byte (
        .CLK     (CLK),
        .RST     (RST),
        .i_valid (byte_valid),
        .i_byte  (byte_data),
        .o_ready (byte_ready),
        .o_tx    (o_tx),
        .o_done  (byte_done),
        .o_state (byte_state)
    );

endmodule

// File: tb/tb_uart_msg_tx.sv
// Bench for uart_msg_tx: per-cycle waveform model, line-level loopback
// decoder, and directed messages with literal expectations.
module tb_uart_msg_tx;

    localparam int BS    = 8;
    localparam int FC    = 16;
    localparam int DB    = 8;
    localparam int FRAME = (BS + 2) * FC;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        i_valid = 1'b0;
    logic [7:0]  i_opt = '0;
    logic [7:0]  i_len = '0;
    logic [63:0] i_data = '0;
    logic        o_ready;
    logic        o_tx;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int act_cnt = 0;

    // Per-cycle expectation {ready, busy, done, tx}; empty queue means idle.
    logic [3:0] exp_q[$];
    logic [7:0] exp_byte_q[$];
    logic [7:0] rx_q[$];
    logic [3:0] cmp_exp;
    logic [3:0] cmp_act;

    int         rx_cnt = 0;
    bit         rx_active = 1'b0;
    logic [7:0] rx_byte = '0;

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    uart_msg_tx #(
        .BYTE_SIZE  (BS),
        .FREQ_COEF  (FC),
        .DATA_BYTES (DB)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .i_valid (i_valid),
        .i_opt   (i_opt),
        .i_len   (i_len),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_tx    (o_tx),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- scoreboard: per-cycle compare ----------------
    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            cmp_act = {o_ready, o_busy, o_done, o_tx};
            cmp_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b1001;
            checks++;
            if (cmp_act !== cmp_exp) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t got rdy/busy/done/tx=%b expected %b",
                         $time, cmp_act, cmp_exp);
            end
        end
    end

    initial forever begin
        @(negedge CLK);
        if (o_busy === 1'b1 && o_done === 1'b0) act_cnt++;
    end

    // ---------------- loopback decoder (mid-bit sampling) ----------------
    initial forever begin
        @(negedge CLK);
        if (RST !== 1'b0) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (o_tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            for (int i = 0; i < BS; i++) begin
                if (rx_cnt == FC * (1 + i) + FC / 2) rx_byte[i] = o_tx;
            end
            if (rx_cnt == FC * (BS + 1) + FC / 2) begin
                chk("rx_stop_bit", o_tx, 1);
                rx_q.push_back(rx_byte);
            end
            if (rx_cnt == FRAME - 1) rx_active = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_msg(input logic [7:0] opt, input logic [7:0] len, input logic [63:0] data);
        int t;
        int n;
        logic [7:0] fb[$];
        logic [7:0] b;
        t = 0;
        while (o_ready !== 1'b1 && t < 4000) begin
            @(posedge CLK); #1;
            t++;
        end
        chk("ready_before_send", o_ready, 1);
        i_valid = 1'b1;
        i_opt   = opt;
        i_len   = len;
        i_data  = data;
        @(posedge CLK); #1;
        i_valid = 1'b0;
        i_opt   = 8'($urandom);
        i_len   = 8'($urandom);
        i_data  = {$urandom, $urandom};
        n = (len > DB) ? DB : int'(len);
        fb.push_back(opt);
        fb.push_back(8'(n));
        for (int k = 0; k < n; k++) fb.push_back(data[k*8 +: 8]);
        foreach (fb[j]) begin
            b = fb[j];
            exp_byte_q.push_back(b);
            for (int c = 0; c < FC; c++) exp_q.push_back(4'b0100);
            for (int i = 0; i < BS; i++)
                for (int c = 0; c < FC; c++) exp_q.push_back({3'b010, b[i]});
            for (int c = 0; c < FC; c++) exp_q.push_back(4'b0101);
        end
        exp_q.push_back(4'b0111);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 5000) begin
            @(posedge CLK); #1;
            t++;
        end
        chk("msg_complete", exp_q.size(), 0);
    endtask

    task automatic check_rx_and_clear();
        chk("rx_count", rx_q.size(), exp_byte_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_byte_q.size(); i++)
            chk("rx_byte", rx_q[i], exp_byte_q[i]);
        rx_q.delete();
        exp_byte_q.delete();
    endtask

    // ---------------- directed tests ----------------
    int   pat[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int   found;

    initial begin
        // Reset idle
        RST = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        chk("rst_tx", o_tx, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_ready", o_ready, 0);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("post_rst_ready", o_ready, 1);
        chk("post_rst_tx", o_tx, 1);
        chk("post_rst_busy", o_busy, 0);
        chk_en = 1'b1;
        repeat (10) @(posedge CLK);
        #1;

        // Basic message
        act_cnt = 0;
        send_msg(8'hA5, 8'd2, 64'h813C);
        for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? FC / 2 : FC) @(posedge CLK);
            #1;
            chk("a5_bit_pattern", o_tx, pat[i]);
        end
        wait_done();
        chk("basic_active_cycles", act_cnt, 640);
        chk("basic_frames", rx_q.size(), 4);
        if (rx_q.size() == 4) begin
            chk("basic_opt", rx_q[0], 8'hA5);
            chk("basic_len", rx_q[1], 8'h02);
            chk("basic_payload", {rx_q[3], rx_q[2]}, 16'h813C);
        end
        check_rx_and_clear();

        // Zero length
        act_cnt = 0;
        send_msg(8'h11, 8'd0, 64'hDEAD_BEEF_0BAD_F00D);
        wait_done();
        chk("zero_active_cycles", act_cnt, 320);
        chk("zero_ready_after", o_ready, 1);
        chk("zero_frames", rx_q.size(), 2);
        check_rx_and_clear();

        // Length clamp, sent right after the previous DONE
        act_cnt = 0;
        send_msg(8'hC3, 8'd20, 64'h8877_6655_4433_2211);
        wait_done();
        chk("clamp_active_cycles", act_cnt, 1600);
        chk("clamp_frames", rx_q.size(), 10);
        if (rx_q.size() == 10) begin
            chk("clamp_len_byte", rx_q[1], 8'h08);
            chk("clamp_last_data", rx_q[9], 8'h88);
        end
        check_rx_and_clear();

        // Busy ignore
        act_cnt = 0;
        send_msg(8'h42, 8'd1, 64'h99);
        repeat (200) @(posedge CLK);
        #1;
        i_valid = 1'b1;
        i_opt   = 8'h77;
        i_len   = 8'd0;
        repeat (4) @(posedge CLK);
        #1;
        i_valid = 1'b0;
        wait_done();
        chk("busy_active_cycles", act_cnt, 480);
        found = 0;
        foreach (rx_q[i]) if (rx_q[i] == 8'h77) found++;
        chk("busy_no_0x77", found, 0);
        check_rx_and_clear();
        repeat (5) @(posedge CLK);
        #1;

        // Reset during bit 4 of the len byte
        send_msg(8'h33, 8'd3, 64'h00EE_FFC0);
        repeat (FRAME + 5 * FC + 3) @(posedge CLK);
        #1;
        chk_en = 1'b0;
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("midrst_tx", o_tx, 1);
        chk("midrst_done", o_done, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_ready", o_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            chk("midrst_hold_done", o_done, 0);
        end
        RST = 1'b0;
        exp_q.delete();
        exp_byte_q.delete();
        rx_q.delete();
        @(posedge CLK); #1;
        chk("midrst_ready_after", o_ready, 1);
        chk("midrst_tx_after", o_tx, 1);
        chk_en = 1'b1;
        repeat (3) @(posedge CLK);
        #1;

        act_cnt = 0;
        send_msg(8'h5A, 8'd1, 64'hFF);
        wait_done();
        chk("fresh_active_cycles", act_cnt, 480);
        if (rx_q.size() == 3) begin
            chk("fresh_opt", rx_q[0], 8'h5A);
            chk("fresh_data", rx_q[2], 8'hFF);
        end
        check_rx_and_clear();
        repeat (5) @(posedge CLK);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_msg_tx.md
Name: uart_msg_tx

Overview:
- UART transmitter producing framed messages: opt byte, len byte, then len payload bytes.
- The message format and payload packing are the ones our message receiver decodes, so a TX-to-RX loopback returns identical opt/len/data.
- Sits between the command/response logic and the serial output pin; one message is accepted per handshake.
- Contains its own bit-period counter; no external baud enable.

Parameters:
- BYTE_SIZE, 8: bits per UART character.
- FREQ_COEF, 16: CLK cycles per serial bit (>=2).
- DATA_BYTES, 8: maximum payload bytes held in one message.
- IN_DATA_SIZE, DATA_BYTES*BYTE_SIZE: width of payload input.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- i_valid  in  1  message request.
- i_opt  in  BYTE_SIZE  option/command byte.
- i_len  in  BYTE_SIZE  payload byte count.
- i_data  in  IN_DATA_SIZE  payload; byte k = i_data[k*BYTE_SIZE +: BYTE_SIZE], byte 0 sent first.
- o_ready  out  1  high when a new message can be accepted.
- o_tx  out  1  serial line, idle high.
- o_busy  out  1  message in progress.
- o_done  out  1  one-cycle pulse after the last stop bit completes.

Behaviour:
- Reset: state IDLE, o_tx=1, o_busy=0, o_done=0, o_ready=0 while RST high. o_ready=1 from the first cycle after RST falls. All counters are cleared.
- RST mid-message aborts immediately:
  - o_tx=1 on the next edge.
  - No o_done pulse.
  - The partial frame is discarded.
- Handshake:
  - A message is accepted on the cycle with i_valid && o_ready.
  - opt, len and data are latched in that cycle; inputs are don't-care afterwards.
  - o_ready = (state==IDLE); it drops the cycle after acceptance.
  - i_valid while not ready is ignored, with no queuing.
- Length clamp: effective len = min(i_len, DATA_BYTES). The transmitted len byte is the clamped value.
- Byte sequence: opt, len, data[0] .. data[len-1]. len=0 sends only two characters.
- Character frame:
  - 1 start bit (0).
  - BYTE_SIZE data bits, LSB first.
  - 1 stop bit (1).
  - Each bit holds for exactly FREQ_COEF cycles.
- Latency: the start bit of opt appears on o_tx in the cycle after acceptance. The bit counter restarts at acceptance, so the first bit is a full period.
- Back-to-back characters: the next start bit follows its stop bit immediately, with no idle gap.
- Total line-active time = (2+len)*(BYTE_SIZE+2)*FREQ_COEF cycles.
- FSM:
  - IDLE -> START on accept.
  - START -> DATA after one period.
  - DATA -> STOP after BYTE_SIZE periods.
  - STOP -> START if bytes remain, else -> DONE.
  - DONE -> IDLE after one cycle; o_done=1 and o_tx=1 in DONE.
  - o_busy=1 in START/DATA/STOP/DONE.
- Counters:
  - Baud counter: $clog2(FREQ_COEF) bits, wraps at FREQ_COEF-1.
  - Bit index: $clog2(BYTE_SIZE+1) bits.
  - Byte index: $clog2(DATA_BYTES+3) bits.
  - No wrap-around beyond the computed limits.
- A new message can be accepted in the cycle after DONE (IDLE). The minimum inter-message gap is 1 idle-high cycle plus the DONE cycle.
- o_tx is registered, so it is glitch-free.

Decomposition:
- Shared package uart_pkg holds:
  - default BYTE_SIZE and FREQ_COEF;
  - the frame constants START_BIT=0 and STOP_BIT=1;
  - the tx FSM state encoding (IDLE, START, DATA, STOP, DONE).
- One natural sub-module, uart_tx_byte:
  - serializes a single character with its own baud counter;
  - interface: valid/ready in, o_tx out, done pulse.
- uart_msg_tx sequences opt/len/payload through uart_tx_byte.

Test Plan:
- Reset idle: hold RST 5 cycles, then release -> o_tx=1, o_busy=0, o_ready=1 next cycle, o_done never pulses.
- Basic message (FREQ_COEF=16):
  - Stimulus: opt=0xA5, len=2, data bytes 0x3C, 0x81.
  - Expect 4 frames totalling 640 cycles of activity.
  - Expect the bit pattern 0,1,0,1,0,0,1,0,1,1 for 0xA5.
  - Expect o_done 1 cycle after the last stop bit.
  - Loopback into the receiver yields o_opt=0xA5, o_len=2, payload 0x813C.
- Zero length: opt=0x11, len=0 -> exactly 2 frames (320 cycles), then o_done, then o_ready=1.
- Clamp: len=20, DATA_BYTES=8 -> len byte sent as 0x08, 10 frames total, data[0..7] only.
- Busy ignore: assert i_valid with new opt=0x77 mid-message -> ignored; the original message completes unchanged; 0x77 is never sent.
- Reset mid-frame: assert RST during bit 4 of the len byte -> o_tx=1 next cycle, no o_done. A fresh message (opt=0x5A, len=1, data 0xFF) then transmits correctly.
